if_id_stage: RTL and testbench

- Pipeline register between instruction fetch and decode in the MIPS core.
- Latches the fetched instruction and PC+1, and squashes the slot on a taken branch or jump.
- Detects load-use hazards and drives the fetch hold control (pc_write_en).
- Decodes J/JAL early and returns jump_flag/jump_pc to fetch.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_id_stage_hazard_detect.sv | 20 ++
 rtl/if_id_stage.sv | 81 ++++++++
 tb/tb_if_id_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode constants, NOP word and instruction field positions.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction
endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// hazard_detect: load-use hazard between the instruction in ID and a load in ID/EX.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       valid,
    input  logic       mem_read,
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] idex_rt,
    output logic       hazard
);
    logic uses_rs, uses_rt;
    always_comb begin
        uses_rs = !is_jump_op(op);
        uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        hazard  = valid && mem_read && (idex_rt != 5'd0) &&
                  ((uses_rs && rs == idex_rt) || (uses_rt && rt == idex_rt));
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with flush, load-use stall and early J/JAL redirect.
// Define IF_ID_DELAY_SLOT_EN for branch-delay-slot semantics (no squash after a jump).
module if_id_stage #(
    parameter int                 PC_W     = 10,
    parameter int                 INSTR_W  = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               branch_taken,
    input  logic               idex_mem_read,
    input  logic [4:0]         idex_rt,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc_next,
    output logic               id_valid,
    output logic               id_bubble,
    output logic               pc_write_en,
    output logic               jump_flag,
    output logic [PC_W-1:0]    jump_pc
);
    import mips_pkg::*;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_next_q, id_pc_next_d;
    logic               id_valid_q, id_valid_d;
    logic               hazard, is_jump;
    hazard_detect u_hazard (
        .valid    (id_valid_q),
        .mem_read (idex_mem_read),
        .op       (id_instr_q[OP_MSB:OP_LSB]),
        .rs       (id_instr_q[RS_MSB:RS_LSB]),
        .rt       (id_instr_q[RT_MSB:RT_LSB]),
        .idex_rt  (idex_rt),
        .hazard   (hazard)
    );
    always_comb begin
        is_jump     = id_valid_q && is_jump_op(id_instr_q[OP_MSB:OP_LSB]);
        pc_write_en = !hazard || branch_taken;
        id_bubble   = hazard && !branch_taken;
        jump_flag   = is_jump && !hazard && !branch_taken;
        jump_pc     = id_instr_q[PC_W-1:0];
        id_instr    = id_instr_q;
        id_pc_next  = id_pc_next_q;
        id_valid    = id_valid_q;
    end
    // Flushed/squashed slots keep the old pc_next; it is meaningless while id_valid=0.
    always_comb begin
        id_instr_d   = id_instr_q;
        id_pc_next_d = id_pc_next_q;
        id_valid_d   = id_valid_q;
        if (reset) begin
            id_instr_d   = NOP_WORD;
            id_pc_next_d = '0;
            id_valid_d   = 1'b0;
        end else if (clk_en) begin
            if (branch_taken) begin
                id_instr_d = NOP_WORD;
                id_valid_d = 1'b0;
            end else if (hazard) begin
                id_valid_d = id_valid_q;
`ifdef IF_ID_DELAY_SLOT_EN
`else
            end else if (jump_flag) begin
                id_instr_d = NOP_WORD;
                id_valid_d = 1'b0;
`endif
            end else begin
                id_instr_d   = if_instr;
                id_pc_next_d = if_pc + PC_W'(1);
                id_valid_d   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        id_instr_q   <= id_instr_d;
        id_pc_next_q <= id_pc_next_d;
        id_valid_q   <= id_valid_d;
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vector table plus randomized run against a reference model of if_id_stage.
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        reset, clk_en, branch_taken, idex_mem_read;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
    logic [4:0]  idex_rt;
    logic [31:0] id_instr;
    logic [9:0]  id_pc_next, jump_pc;
    logic        id_valid, id_bubble, pc_write_en, jump_flag;
    int          n_chk = 0;
    int          n_fail = 0;

    if_id_stage dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .if_instr(if_instr), .if_pc(if_pc),
        .branch_taken(branch_taken), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .id_instr(id_instr), .id_pc_next(id_pc_next), .id_valid(id_valid), .id_bubble(id_bubble),
        .pc_write_en(pc_write_en), .jump_flag(jump_flag), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ce, br, mr;
        logic [4:0]  rt;
        logic [31:0] instr;
        logic [9:0]  pc;
        logic        e_pwe, e_bub, e_jf;
        logic [9:0]  e_jpc;
        logic [31:0] e_instr;
        logic [9:0]  e_pc;
        logic        chk_pc, e_valid;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [31:0] m_instr;
    logic [9:0]  m_pc;
    logic        m_pc_known, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_hazard(input logic [31:0] ins, input logic vld,
                                        input logic mr, input logic [4:0] lrt);
        int op, rs, rt;
        logic urs, urt;
        op  = int'(ins >> 26);
        rs  = int'((ins >> 21) & 32'd31);
        rt  = int'((ins >> 16) & 32'd31);
        urs = !(op == 2 || op == 3);
        urt = (op == 0 || op == 4 || op == 5 || op == 43);
        return vld && mr && lrt != 0 && ((urs && rs == int'(lrt)) || (urt && rt == int'(lrt)));
    endfunction

    function automatic vec_t mk(input logic rst, ce, br, mr, input logic [4:0] rt,
                                input logic [31:0] instr, input logic [9:0] pc,
                                input logic pwe, bub, jf, input logic [9:0] jpc,
                                input logic [31:0] ei, input logic [9:0] ep,
                                input logic cp, ev);
        vec_t v;
        v.rst = rst; v.ce = ce; v.br = br; v.mr = mr; v.rt = rt; v.instr = instr; v.pc = pc;
        v.e_pwe = pwe; v.e_bub = bub; v.e_jf = jf; v.e_jpc = jpc;
        v.e_instr = ei; v.e_pc = ep; v.chk_pc = cp; v.e_valid = ev;
        return v;
    endfunction

    initial begin
        reset = 1'b1; clk_en = 1'b0; branch_taken = 1'b0; idex_mem_read = 1'b0;
        idex_rt = 5'd0; if_instr = 32'h0; if_pc = 10'h0;
        @(posedge clk); #1;
        chk("reset_instr", id_instr, 32'h0);
        chk("reset_pc", 32'(id_pc_next), 32'h0);
        chk("reset_valid", 32'(id_valid), 32'h0);
        chk("reset_pwe", 32'(pc_write_en), 32'h1);
        chk("reset_jf", 32'(jump_flag), 32'h0);
        chk("reset_bubble", 32'(id_bubble), 32'h0);
        reset = 1'b0;
        //          rst ce br mr rt     instr          pc      pwe bub jf jpc      e_instr        e_pc    cp ev
        vecs.push_back(mk(0, 1, 0, 0, 5'd0, 32'h2008_0005, 10'd4,   1, 0, 0, 10'h000, 32'h2008_0005, 10'd5,   1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5'd8, 32'h0022_1820, 10'd5,   1, 0, 0, 10'h005, 32'h0022_1820, 10'd6,   1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5'd2, 32'h8C01_0000, 10'd6,   0, 1, 0, 10'h020, 32'h0022_1820, 10'd6,   1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5'd2, 32'h8C01_0000, 10'd6,   0, 1, 0, 10'h020, 32'h0022_1820, 10'd6,   1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5'd1, 32'h0022_1820, 10'd7,   0, 1, 0, 10'h020, 32'h0022_1820, 10'd6,   1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 5'd2, 32'h0022_1820, 10'd7,   1, 0, 0, 10'h020, 32'h0022_1820, 10'd8,   1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 5'd0, 32'h0800_0030, 10'd8,   1, 0, 0, 10'h020, 32'h0800_0030, 10'd9,   1, 1));
`ifdef IF_ID_DELAY_SLOT_EN
        vecs.push_back(mk(0, 1, 0, 1, 5'd5, 32'h2008_0005, 10'd9,   1, 0, 1, 10'h030, 32'h2008_0005, 10'd10,  1, 1));
`else
        vecs.push_back(mk(0, 1, 0, 1, 5'd5, 32'h2008_0005, 10'd9,   1, 0, 1, 10'h030, 32'h0000_0000, 10'd0,   0, 0));
`endif
        vecs.push_back(mk(0, 1, 0, 0, 5'd0, 32'h0C00_0040, 10'd10,  1, 0, 0, 10'h000, 32'h0C00_0040, 10'd11,  1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 5'd0, 32'h2008_0005, 10'd11,  1, 0, 0, 10'h040, 32'h0000_0000, 10'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 5'd0, 32'h0022_1820, 10'd20,  1, 0, 0, 10'h000, 32'h0022_1820, 10'd21,  1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 5'd2, 32'h2008_0005, 10'd22,  1, 0, 0, 10'h020, 32'h0000_0000, 10'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 5'd0, 32'h1234_5678, 10'h3FF, 1, 0, 0, 10'h000, 32'h1234_5678, 10'd0,   1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 32'h2008_0005, 10'd40,  1, 0, 0, 10'h278, 32'h1234_5678, 10'd0,   1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 5'd20, 32'h2008_0005, 10'd41, 0, 1, 0, 10'h278, 32'h1234_5678, 10'd0,   1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 5'd17, 32'h2008_0005, 10'd42, 1, 0, 0, 10'h278, 32'h1234_5678, 10'd0,   1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 5'd17, 32'h2008_0005, 10'd43, 0, 1, 0, 10'h278, 32'h0000_0000, 10'd0,   1, 0));
        foreach (vecs[i]) begin
            reset = vecs[i].rst; clk_en = vecs[i].ce; branch_taken = vecs[i].br;
            idex_mem_read = vecs[i].mr; idex_rt = vecs[i].rt;
            if_instr = vecs[i].instr; if_pc = vecs[i].pc;
            #1;
            chk($sformatf("row%0d_pwe", i), 32'(pc_write_en), 32'(vecs[i].e_pwe));
            chk($sformatf("row%0d_bubble", i), 32'(id_bubble), 32'(vecs[i].e_bub));
            chk($sformatf("row%0d_jf", i), 32'(jump_flag), 32'(vecs[i].e_jf));
            chk($sformatf("row%0d_jpc", i), 32'(jump_pc), 32'(vecs[i].e_jpc));
            @(posedge clk); #1;
            chk($sformatf("row%0d_instr", i), id_instr, vecs[i].e_instr);
            chk($sformatf("row%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_pc) chk($sformatf("row%0d_pc", i), 32'(id_pc_next), 32'(vecs[i].e_pc));
        end
        // Randomized run: model starts from the reset state left by the last row.
        m_instr = 32'h0; m_pc = 10'd0; m_pc_known = 1'b1; m_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [5:0] ops[8];
            logic hz, jf, m_bub, m_pwe;
            ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
            reset = ($urandom_range(0, 39) == 0);
            clk_en = ($urandom_range(0, 4) != 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            idex_mem_read = $urandom_range(0, 1) == 1;
            idex_rt = 5'($urandom_range(0, 3));
            if_instr = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            if_pc = 10'($urandom);
            hz = ref_hazard(m_instr, m_valid, idex_mem_read, idex_rt);
            jf = m_valid && (m_instr[31:26] == 6'd2 || m_instr[31:26] == 6'd3) && !hz && !branch_taken;
            m_pwe = !hz || branch_taken;
            m_bub = hz && !branch_taken;
            #1;
            chk("rand_pwe", 32'(pc_write_en), 32'(m_pwe));
            chk("rand_bubble", 32'(id_bubble), 32'(m_bub));
            chk("rand_jf", 32'(jump_flag), 32'(jf));
            chk("rand_jpc", 32'(jump_pc), m_instr % 1024);
            if (reset) begin
                m_instr = 32'h0; m_pc = 10'd0; m_pc_known = 1'b1; m_valid = 1'b0;
            end else if (clk_en) begin
                if (branch_taken) begin
                    m_instr = 32'h0; m_pc_known = 1'b0; m_valid = 1'b0;
                end else if (hz) begin
                    m_valid = m_valid;
`ifndef IF_ID_DELAY_SLOT_EN
                end else if (jf) begin
                    m_instr = 32'h0; m_pc_known = 1'b0; m_valid = 1'b0;
`endif
                end else begin
                    m_instr = if_instr; m_pc = 10'((int'(if_pc) + 1) % 1024);
                    m_pc_known = 1'b1; m_valid = 1'b1;
                end
            end
            @(posedge clk); #1;
            chk("rand_instr", id_instr, m_instr);
            chk("rand_valid", 32'(id_valid), 32'(m_valid));
            if (m_pc_known) chk("rand_pc", 32'(id_pc_next), 32'(m_pc));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
